pwm_timebase: RTL and testbench

Parametrised timebase for the PWM peripheral, successor to the fixed 16-bit prescaled up/down counter. Adds configurable counter and prescaler widths, four counting modes (up, down, centre-aligned up-down, one-shot), shadowed period/prescale registers committed only at update events, and registered overflow/underflow event pulses for the compare channels and interrupt logic downstream.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_prescaler.sv | 44 ++++
 rtl/pwm_timebase.sv | 195 +++++++++++++++++++
 tb/tb_pwm_timebase.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
//==============================================================================
// Module      : pwm_pkg
// Description : Counting-mode encoding and helpers shared by the PWM timebase,
//               compare channels and register file.
// Revision    : 1.0
//==============================================================================
package pwm_pkg;

    typedef logic [1:0] pwm_mode_t;

    localparam pwm_mode_t MODE_UP      = 2'd0;
    localparam pwm_mode_t MODE_DOWN    = 2'd1;
    localparam pwm_mode_t MODE_UPDN    = 2'd2;
    localparam pwm_mode_t MODE_ONESHOT = 2'd3;

    // Direction a counter starts with after a synchronous clear into mode m.
    function automatic logic start_dir(input pwm_mode_t m);
        return (m != MODE_DOWN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
//==============================================================================
// Module      : pwm_prescaler
// Description : Prescaler with shadowed reload value; ticks once every
//               psc_act+1 advancing cycles.
// Revision    : 1.0
//==============================================================================
module pwm_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_advance,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [PSC_W-1:0] i_load_val,
    output logic             o_tick
);

    logic [PSC_W-1:0] r_psc_cnt;
    logic [PSC_W-1:0] r_psc_act;

    assign o_tick = i_advance && (r_psc_cnt == r_psc_act);

    // A new reload value only arrives together with a clear or a tick, so the
    // counter always restarts from zero against the freshly loaded value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc_cnt <= '0;
            r_psc_act <= '0;
        end else begin
            if (i_clear || o_tick) begin
                r_psc_cnt <= '0;
            end else if (i_advance) begin
                r_psc_cnt <= r_psc_cnt + PSC_W'(1);
            end
            if (i_load) begin
                r_psc_act <= i_load_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
//==============================================================================
// Module      : pwm_timebase
// Description : Prescaled PWM counter with up, down, centre-aligned and
//               one-shot modes, shadowed period/prescale and event pulses.
// Revision    : 1.0
//==============================================================================
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             count_reset,
    input  logic [1:0]       mode,
    input  logic             arm,
    input  logic [CNT_W-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    input  logic             cfg_wr,
    output logic [CNT_W-1:0] count_val,
    output logic             dir,
    output logic             ovf,
    output logic             unf,
    output logic             running
);

    pwm_mode_t        r_mode;
    pwm_mode_t        w_mode_nxt;
    logic [CNT_W-1:0] r_per_pend;
    logic [CNT_W-1:0] w_per_pend_nxt;
    logic [CNT_W-1:0] r_per_act;
    logic [PSC_W-1:0] r_psc_pend;
    logic [PSC_W-1:0] w_psc_pend_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             r_unf;
    logic             w_unf_nxt;
    logic             r_running;
    logic             w_running_nxt;
    logic             w_oneshot;
    logic             w_arm_go;
    logic             w_advance;
    logic             w_tick;
    logic             w_commit;
    logic             w_psc_clear;

    // A write in the same cycle as a commit is captured first, so the new
    // value is the one that becomes active.
    assign w_per_pend_nxt = cfg_wr ? period   : r_per_pend;
    assign w_psc_pend_nxt = cfg_wr ? prescale : r_psc_pend;

    assign w_oneshot = (r_mode == MODE_ONESHOT);
    assign w_arm_go  = w_oneshot && arm;
    assign w_advance = w_oneshot ? r_running : en;

    pwm_prescaler #(
        .PSC_W(PSC_W)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_advance (w_advance),
        .i_clear   (w_psc_clear),
        .i_load    (w_commit),
        .i_load_val(w_psc_pend_nxt),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_dir_nxt     = r_dir;
        w_ovf_nxt     = 1'b0;
        w_unf_nxt     = 1'b0;
        w_running_nxt = r_running;
        w_mode_nxt    = r_mode;
        w_commit      = 1'b0;
        w_psc_clear   = 1'b0;

        if (count_reset) begin
            w_cnt_nxt     = '0;
            w_dir_nxt     = start_dir(pwm_mode_t'(mode));
            w_running_nxt = 1'b0;
            w_mode_nxt    = pwm_mode_t'(mode);
            w_commit      = 1'b1;
            w_psc_clear   = 1'b1;
        end else if (w_arm_go) begin
            w_cnt_nxt     = '0;
            w_dir_nxt     = 1'b1;
            w_running_nxt = 1'b1;
            w_commit      = 1'b1;
            w_psc_clear   = 1'b1;
        end else begin
            if (!w_oneshot) begin
                w_running_nxt = en;
            end
            if (w_tick) begin
                case (r_mode)
                    MODE_UP: begin
                        if (r_cnt >= r_per_act) begin
                            w_cnt_nxt = '0;
                            w_ovf_nxt = 1'b1;
                            w_commit  = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                    MODE_DOWN: begin
                        w_dir_nxt = 1'b0;
                        if (r_cnt == '0) begin
                            w_cnt_nxt = w_per_pend_nxt;
                            w_unf_nxt = 1'b1;
                            w_commit  = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                    MODE_UPDN: begin
                        if (r_dir && (r_cnt >= r_per_act)) begin
                            // A zero period collapses the triangle into a
                            // single point that is both top and bottom.
                            if (r_per_act == '0) begin
                                w_cnt_nxt = '0;
                                w_ovf_nxt = 1'b1;
                                w_unf_nxt = 1'b1;
                                w_commit  = 1'b1;
                            end else begin
                                w_dir_nxt = 1'b0;
                                w_cnt_nxt = r_per_act - CNT_W'(1);
                                w_ovf_nxt = 1'b1;
                            end
                        end else if (!r_dir && (r_cnt == '0)) begin
                            w_dir_nxt = 1'b1;
                            w_cnt_nxt = CNT_W'(1);
                            w_unf_nxt = 1'b1;
                            w_commit  = 1'b1;
                        end else if (r_dir) begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        if (r_cnt >= r_per_act) begin
                            w_cnt_nxt     = '0;
                            w_ovf_nxt     = 1'b1;
                            w_running_nxt = 1'b0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= MODE_UP;
            r_per_pend <= '0;
            r_psc_pend <= '0;
            r_per_act  <= '0;
            r_cnt      <= '0;
            r_dir      <= 1'b1;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_per_pend <= w_per_pend_nxt;
            r_psc_pend <= w_psc_pend_nxt;
            if (w_commit) begin
                r_per_act <= w_per_pend_nxt;
            end
            r_cnt     <= w_cnt_nxt;
            r_dir     <= w_dir_nxt;
            r_ovf     <= w_ovf_nxt;
            r_unf     <= w_unf_nxt;
            r_running <= w_running_nxt;
        end
    end

    assign count_val = r_cnt;
    assign dir       = r_dir;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign running   = r_running;

endmodule
`default_nettype wire

// File: tb/tb_pwm_timebase.sv
`default_nettype none
//==============================================================================
// Module      : tb_pwm_timebase
// Description : Directed vector table plus randomized run against a
//               behavioural model of the PWM timebase.
// Revision    : 1.0
//==============================================================================
module tb_pwm_timebase;
    import pwm_pkg::*;

    localparam int CNT_W  = 16;
    localparam int PSC_W  = 8;
    localparam int N_RAND = 4000;

    localparam int S_UP      = 0;
    localparam int S_UPDN    = 1;
    localparam int S_DOWN    = 2;
    localparam int S_ONESHOT = 3;
    localparam int S_CR_OVR  = 4;
    localparam int S_PER0    = 5;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             count_reset;
    logic [1:0]       mode;
    logic             arm;
    logic [CNT_W-1:0] period;
    logic [PSC_W-1:0] prescale;
    logic             cfg_wr;
    logic [CNT_W-1:0] count_val;
    logic             dir;
    logic             ovf;
    logic             unf;
    logic             running;

    pwm_timebase #(
        .CNT_W(CNT_W),
        .PSC_W(PSC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .count_reset(count_reset),
        .mode       (mode),
        .arm        (arm),
        .period     (period),
        .prescale   (prescale),
        .cfg_wr     (cfg_wr),
        .count_val  (count_val),
        .dir        (dir),
        .ovf        (ovf),
        .unf        (unf),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int       sec;
        bit       en;
        bit       cr;
        bit [1:0] mode;
        bit       arm;
        int       per;
        int       psc;
        bit       wr;
        int       e_cnt;
        bit       e_dir;
        bit       e_ovf;
        bit       e_unf;
        bit       e_run;
    } vec_t;

    vec_t vecs[$];

    function automatic string sec_name(input int s);
        case (s)
            S_UP:      return "up_p3_psc1";
            S_UPDN:    return "updn_p3";
            S_DOWN:    return "down_reload";
            S_ONESHOT: return "oneshot_p5";
            S_CR_OVR:  return "creset_override";
            default:   return "period0";
        endcase
    endfunction

    task automatic add(input int sec, input bit a_en, input bit a_cr, input bit [1:0] a_mode,
                       input bit a_arm, input int a_per, input int a_psc, input bit a_wr,
                       input int e_cnt, input bit e_dir, input bit e_ovf, input bit e_unf,
                       input bit e_run);
        vec_t v;
        v.sec = sec;   v.en = a_en;   v.cr = a_cr;   v.mode = a_mode; v.arm = a_arm;
        v.per = a_per; v.psc = a_psc; v.wr = a_wr;
        v.e_cnt = e_cnt; v.e_dir = e_dir; v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_run = e_run;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit d_en, input bit d_cr, input bit [1:0] d_mode, input bit d_arm,
                         input int d_per, input int d_psc, input bit d_wr);
        en          = d_en;
        count_reset = d_cr;
        mode        = d_mode;
        arm         = d_arm;
        period      = CNT_W'(d_per);
        prescale    = PSC_W'(d_psc);
        cfg_wr      = d_wr;
    endtask

    task automatic check_out(input string tag, input int e_cnt, input bit e_dir, input bit e_ovf,
                             input bit e_unf, input bit e_run);
        checks++;
        if (count_val !== CNT_W'(e_cnt) || dir !== e_dir || ovf !== e_ovf ||
            unf !== e_unf || running !== e_run) begin
            failures++;
            $display("FAIL %s @%0t: got cnt=%0d dir=%0b ovf=%0b unf=%0b run=%0b, want cnt=%0d dir=%0b ovf=%0b unf=%0b run=%0b",
                     tag, $time, count_val, dir, ovf, unf, running, e_cnt, e_dir, e_ovf, e_unf, e_run);
        end
    endtask

    // Behavioural model: the prescaler is a countdown of cycles left until
    // the next tick, and the centre-aligned count is a phase along the
    // triangle 0..2P rather than a direction flag.
    int m_mode, m_pper, m_ppsc, m_per, m_psc, m_wait, m_cnt, m_ph;
    bit m_dir, m_ovf, m_unf, m_run;

    task automatic model_reset();
        m_mode = 0; m_pper = 0; m_ppsc = 0; m_per = 0; m_psc = 0;
        m_wait = 0; m_cnt = 0; m_ph = 0;
        m_dir = 1'b1; m_ovf = 1'b0; m_unf = 1'b0; m_run = 1'b0;
    endtask

    task automatic model_commit();
        m_per = m_pper;
        m_psc = m_ppsc;
    endtask

    task automatic model_step(input bit t_en, input bit t_cr, input int t_mode, input bit t_arm,
                              input int t_per, input int t_psc, input bit t_wr);
        bit adv;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (t_wr) begin
            m_pper = t_per;
            m_ppsc = t_psc;
        end
        if (t_cr) begin
            m_mode = t_mode;
            model_commit();
            m_cnt = 0; m_ph = 0; m_dir = (t_mode != 1); m_run = 1'b0; m_wait = m_psc;
        end else if (m_mode == 3 && t_arm) begin
            model_commit();
            m_cnt = 0; m_dir = 1'b1; m_run = 1'b1; m_wait = m_psc;
        end else begin
            adv = (m_mode == 3) ? m_run : t_en;
            if (m_mode != 3) m_run = t_en;
            if (adv) begin
                if (m_wait > 0) begin
                    m_wait--;
                end else begin
                    case (m_mode)
                        0: begin
                            if (m_cnt >= m_per) begin
                                m_cnt = 0; m_ovf = 1'b1; model_commit();
                            end else m_cnt++;
                        end
                        1: begin
                            if (m_cnt == 0) begin
                                model_commit(); m_cnt = m_per; m_unf = 1'b1;
                            end else m_cnt--;
                        end
                        2: begin
                            if (m_per == 0) begin
                                m_ovf = 1'b1; m_unf = 1'b1; model_commit();
                                m_cnt = 0; m_dir = 1'b1; m_ph = 0;
                            end else begin
                                m_ph++;
                                if (m_ph == m_per + 1) m_ovf = 1'b1;
                                if (m_ph > 2 * m_per) begin
                                    m_ph = 1; m_unf = 1'b1; model_commit();
                                end
                                if (m_ph <= m_per) begin
                                    m_cnt = m_ph; m_dir = 1'b1;
                                end else begin
                                    m_cnt = 2 * m_per - m_ph; m_dir = 1'b0;
                                end
                            end
                        end
                        default: begin
                            if (m_cnt >= m_per) begin
                                m_cnt = 0; m_ovf = 1'b1; m_run = 1'b0;
                            end else m_cnt++;
                        end
                    endcase
                    m_wait = m_psc;
                end
            end
        end
    endtask

    int up_seq[8];
    int r_en, r_cr, r_mode, r_arm, r_per, r_psc, r_wr;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, MODE_UP, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 0, 1, 0, 0, 0);
        rst_n = 1'b1;

        // UP, period 3, prescale 1: each value held two cycles
        up_seq = '{0, 1, 1, 2, 2, 3, 3, 0};
        add(S_UP, 0, 1, MODE_UP, 0, 3, 1, 1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 16; k++)
            add(S_UP, 1, 0, MODE_UP, 0, 0, 0, 0, up_seq[k % 8], 1, (k % 8) == 7, 0, 1);
        add(S_UP, 0, 0, MODE_UP, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // UPDN, period 3, prescale 0; then count_reset into UP at cnt 2 dir 0
        add(S_UPDN, 0, 1, MODE_UPDN, 0, 3, 0, 1, 0, 1, 0, 0, 0);
        add(S_UPDN, 1, 0, MODE_UPDN, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        add(S_UPDN, 1, 0, MODE_UPDN, 0, 0, 0, 0, 2, 1, 0, 0, 1);
        add(S_UPDN, 1, 0, MODE_UPDN, 0, 0, 0, 0, 3, 1, 0, 0, 1);
        add(S_UPDN, 1, 0, MODE_UPDN, 0, 0, 0, 0, 2, 0, 1, 0, 1);
        add(S_UPDN, 1, 0, MODE_UPDN, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        add(S_UPDN, 1, 0, MODE_UPDN, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(S_UPDN, 1, 0, MODE_UPDN, 0, 0, 0, 0, 1, 1, 0, 1, 1);
        add(S_UPDN, 1, 0, MODE_UPDN, 0, 0, 0, 0, 2, 1, 0, 0, 1);
        add(S_UPDN, 1, 0, MODE_UPDN, 0, 0, 0, 0, 3, 1, 0, 0, 1);
        add(S_UPDN, 1, 0, MODE_UPDN, 0, 0, 0, 0, 2, 0, 1, 0, 1);
        add(S_UPDN, 1, 1, MODE_UP,   0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(S_UPDN, 1, 0, MODE_UP,   0, 0, 0, 0, 1, 1, 0, 0, 1);
        add(S_UPDN, 1, 0, MODE_UP,   0, 0, 0, 0, 2, 1, 0, 0, 1);
        add(S_UPDN, 1, 0, MODE_UP,   0, 0, 0, 0, 3, 1, 0, 0, 1);
        add(S_UPDN, 1, 0, MODE_UP,   0, 0, 0, 0, 0, 1, 1, 0, 1);

        // DOWN, period 4, rewritten to 2 mid-count
        add(S_DOWN, 0, 1, MODE_DOWN, 0, 4, 0, 1, 0, 0, 0, 0, 0);
        add(S_DOWN, 1, 0, MODE_DOWN, 0, 0, 0, 0, 4, 0, 0, 1, 1);
        add(S_DOWN, 1, 0, MODE_DOWN, 0, 0, 0, 0, 3, 0, 0, 0, 1);
        add(S_DOWN, 1, 0, MODE_DOWN, 0, 0, 0, 0, 2, 0, 0, 0, 1);
        add(S_DOWN, 1, 0, MODE_DOWN, 0, 2, 0, 1, 1, 0, 0, 0, 1);
        add(S_DOWN, 1, 0, MODE_DOWN, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(S_DOWN, 1, 0, MODE_DOWN, 0, 0, 0, 0, 2, 0, 0, 1, 1);
        add(S_DOWN, 1, 0, MODE_DOWN, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        add(S_DOWN, 1, 0, MODE_DOWN, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(S_DOWN, 1, 0, MODE_DOWN, 0, 0, 0, 0, 2, 0, 0, 1, 1);

        // ONESHOT, period 5; en is ignored, a second arm restarts
        add(S_ONESHOT, 0, 1, MODE_ONESHOT, 0, 5, 0, 1, 0, 1, 0, 0, 0);
        add(S_ONESHOT, 1, 0, MODE_ONESHOT, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        for (int k = 1; k <= 5; k++)
            add(S_ONESHOT, 0, 0, MODE_ONESHOT, 0, 0, 0, 0, k, 1, 0, 0, 1);
        add(S_ONESHOT, 0, 0, MODE_ONESHOT, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        add(S_ONESHOT, 0, 0, MODE_ONESHOT, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(S_ONESHOT, 1, 0, MODE_ONESHOT, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(S_ONESHOT, 0, 0, MODE_ONESHOT, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        add(S_ONESHOT, 0, 0, MODE_ONESHOT, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        add(S_ONESHOT, 0, 0, MODE_ONESHOT, 0, 0, 0, 0, 2, 1, 0, 0, 1);
        add(S_ONESHOT, 0, 0, MODE_ONESHOT, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        add(S_ONESHOT, 0, 0, MODE_ONESHOT, 0, 0, 0, 0, 1, 1, 0, 0, 1);

        // count_reset beats a coincident arm and tick; coincident write is committed
        add(S_CR_OVR, 0, 1, MODE_ONESHOT, 1, 2, 0, 1, 0, 1, 0, 0, 0);
        add(S_CR_OVR, 0, 0, MODE_ONESHOT, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        add(S_CR_OVR, 0, 0, MODE_ONESHOT, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        add(S_CR_OVR, 0, 0, MODE_ONESHOT, 0, 0, 0, 0, 2, 1, 0, 0, 1);
        add(S_CR_OVR, 0, 0, MODE_ONESHOT, 0, 0, 0, 0, 0, 1, 1, 0, 0);

        // period 0 in every mode
        add(S_PER0, 0, 1, MODE_UP, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(S_PER0, 1, 0, MODE_UP, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        add(S_PER0, 1, 0, MODE_UP, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        add(S_PER0, 0, 1, MODE_DOWN, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(S_PER0, 1, 0, MODE_DOWN, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(S_PER0, 1, 0, MODE_DOWN, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(S_PER0, 0, 1, MODE_UPDN, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(S_PER0, 1, 0, MODE_UPDN, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        add(S_PER0, 1, 0, MODE_UPDN, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        add(S_PER0, 0, 1, MODE_ONESHOT, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(S_PER0, 0, 0, MODE_ONESHOT, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        add(S_PER0, 0, 0, MODE_ONESHOT, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        add(S_PER0, 0, 0, MODE_ONESHOT, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].cr, vecs[i].mode, vecs[i].arm,
                  vecs[i].per, vecs[i].psc, vecs[i].wr);
            @(posedge clk);
            #1;
            check_out(sec_name(vecs[i].sec), vecs[i].e_cnt, vecs[i].e_dir,
                      vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_run);
        end

        // Asynchronous reset mid-count in UPDN at cnt 2, dir 0
        drive(0, 1, MODE_UPDN, 0, 3, 0, 1);
        @(posedge clk);
        #1;
        check_out("rstn_setup", 0, 1, 0, 0, 0);
        drive(1, 0, MODE_UPDN, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        check_out("rstn_pre", 2, 0, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rstn_async", 0, 1, 0, 0, 0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("rstn_release", 0, 1, 0, 0, 0);
        en = 1'b1;
        @(posedge clk);
        #1;
        check_out("rstn_per0_up", 0, 1, 1, 0, 1);

        // Randomized run against the model
        rst_n = 1'b0;
        drive(0, 0, MODE_UP, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N_RAND; i++) begin
            r_en   = ($urandom_range(99) < 80) ? 1 : 0;
            r_cr   = ($urandom_range(99) < 2) ? 1 : 0;
            r_mode = int'($urandom_range(3));
            r_arm  = ($urandom_range(99) < 5) ? 1 : 0;
            r_wr   = ($urandom_range(99) < 10) ? 1 : 0;
            r_per  = int'($urandom_range(6, 1));
            r_psc  = int'($urandom_range(2));
            if (i == 0) begin
                r_cr = 1;
                r_wr = 1;
            end
            drive(r_en[0], r_cr[0], r_mode[1:0], r_arm[0], r_per, r_psc, r_wr[0]);
            model_step(r_en[0], r_cr[0], r_mode, r_arm[0], r_per, r_psc, r_wr[0]);
            @(posedge clk);
            #1;
            check_out("random", m_cnt, m_dir, m_ovf, m_unf, m_run);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
